// File: rtl/flt_add_pipe.sv
// Three-stage pipelined adder for unsigned {exp,man} floats with valid/ready
// handshaking, a passthrough tag and saturation on exponent overflow.
module flt_add_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] in1,
    input  logic [EXP_W+MAN_W-1:0] in2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] out,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_ovf
);

    localparam int unsigned WORD_W = EXP_W + MAN_W;
    localparam int unsigned E_W    = MAN_W + 2;  // {hidden, man, guard}
    localparam int unsigned R_W    = MAN_W + 3;  // aligned sum incl. carry
    localparam int unsigned D_W    = EXP_W + 1;  // signed exponent difference

    // Stage registers
    logic               s1_v;
    logic [E_W-1:0]     s1_big;
    logic [E_W-1:0]     s1_small;
    logic [EXP_W-1:0]   s1_exp;
    logic [TAG_W-1:0]   s1_tag;

    logic               s2_v;
    logic [R_W-1:0]     s2_raw;
    logic [EXP_W-1:0]   s2_exp;
    logic [TAG_W-1:0]   s2_tag;

    // Stall chain: each stage loads when empty or when its content moves on
    logic ld1;
    logic ld2;
    logic ld3;

    // Backpressure propagates combinationally from the output back to in_ready
    always_comb begin
        ld3      = !out_valid || out_ready;
        ld2      = !s2_v || ld3;
        ld1      = !s1_v || ld2;
        in_ready = ld1;
    end

    // Align: pick the larger-exponent operand and shift the other right
    logic [EXP_W-1:0] exp1;
    logic [EXP_W-1:0] exp2;
    logic [D_W-1:0]   diff;
    logic [D_W-1:0]   abs_d;
    logic             swap;
    logic [E_W-1:0]   e1;
    logic [E_W-1:0]   e2;
    logic [E_W-1:0]   big_e;
    logic [E_W-1:0]   small_e;
    logic [E_W-1:0]   small_sh;
    logic [EXP_W-1:0] big_exp;

    always_comb begin
        exp1     = in1[WORD_W-1:MAN_W];
        exp2     = in2[WORD_W-1:MAN_W];
        diff     = {1'b0, exp1} - {1'b0, exp2};
        swap     = diff[D_W-1];
        abs_d    = swap ? (D_W'(0) - diff) : diff;
        e1       = {(|in1), in1[MAN_W-1:0], 1'b0};
        e2       = {(|in2), in2[MAN_W-1:0], 1'b0};
        big_e    = swap ? e2 : e1;
        small_e  = swap ? e1 : e2;
        big_exp  = swap ? exp2 : exp1;
        small_sh = (abs_d >= D_W'(E_W)) ? '0 : (small_e >> abs_d);
    end

    // Stage 1 register: aligned operands
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
        end else if (ld1) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_big   <= big_e;
                s1_small <= small_sh;
                s1_exp   <= big_exp;
                s1_tag   <= in_tag;
            end
        end
    end

    // Stage 2 register: raw mantissa sum
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v <= 1'b0;
        end else if (ld2) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_raw <= {1'b0, s1_big} + {1'b0, s1_small};
                s2_exp <= s1_exp;
                s2_tag <= s1_tag;
            end
        end
    end

    // Normalise by at most one position, round half-up, adjust exponent
    logic [E_W-1:0]   p;
    logic [E_W-1:0]   r;
    logic             rc;
    logic [MAN_W-1:0] man_n;
    logic [D_W-1:0]   exp_out;

    always_comb begin
        p       = s2_raw[R_W-1] ? s2_raw[R_W-1:1] : s2_raw[E_W-1:0];
        r       = {1'b0, p[E_W-1:1]} + E_W'(p[0]);
        rc      = r[E_W-1];
        man_n   = rc ? r[MAN_W:1] : r[MAN_W-1:0];
        exp_out = {1'b0, s2_exp} + D_W'(s2_raw[R_W-1] | rc);
    end

    // Stage 3 / output register: result holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_tag   <= '0;
            out_ovf   <= 1'b0;
        end else if (ld3) begin
            out_valid <= s2_v;
            if (s2_v) begin
                out_tag <= s2_tag;
                out_ovf <= exp_out[EXP_W];
                out     <= exp_out[EXP_W] ? {WORD_W{1'b1}}
                                          : {exp_out[EXP_W-1:0], man_n};
            end
        end
    end

endmodule
